// File: rtl/wb_target_pkg.sv
// Shared types and constants for the Wishbone memory target.
package wb_target_pkg;

    // Wait-state counter width; covers WAIT_STATES up to 15.
    localparam int WAIT_CNT_W = 4;

    // Bus-cycle FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/wb_target_mem.sv
// Word memory with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module wb_target_mem #(
    parameter int DAT_WIDTH = 32,
    parameter int DEPTH     = 256,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic [IDX_W-1:0]       idx,
    input  logic                   wr_en,
    input  logic [DAT_WIDTH/8-1:0] wr_be,
    input  logic [DAT_WIDTH-1:0]   wr_dat,
    input  logic                   rd_en,
    output logic [DAT_WIDTH-1:0]   rd_dat
);
    localparam int NB = DAT_WIDTH / 8;

    logic [DAT_WIDTH-1:0] mem [DEPTH];

    // Update only the byte lanes whose enable is set.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) mem[idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

    // Synchronous read, captured only when a read is being acknowledged.
    always_ff @(posedge clock) begin
        if (rd_en) rd_dat <= mem[idx];
    end

endmodule

// File: rtl/wb_mem_target.sv
// Wishbone classic-cycle target backed by a byte-enabled word memory,
// with a fixed number of wait states and clean handling of aborted cycles.
module wb_mem_target
    import wb_target_pkg::*;
#(
    parameter int ADR_WIDTH   = 32,
    parameter int DAT_WIDTH   = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   t_adr,
    input  logic [DAT_WIDTH-1:0]   t_dat_w,
    output logic [DAT_WIDTH-1:0]   t_dat_r,
    input  logic                   t_cyc,
    input  logic                   t_stb,
    input  logic [DAT_WIDTH/8-1:0] t_sel,
    input  logic                   t_we,
    output logic                   t_ack,
    output logic [15:0]            access_cnt
);
    localparam int NB    = DAT_WIDTH / 8;
    localparam int OFS   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wcnt_q;

    // Request captured in IDLE; the bus is ignored afterwards.
    logic [IDX_W-1:0]     idx_q;
    logic [DAT_WIDTH-1:0] dat_q;
    logic [NB-1:0]        sel_q;
    logic                 we_q;
    logic                 rng_q;

    logic                 req;
    logic                 bus_rng;
    logic [IDX_W-1:0]     bus_idx;
    logic [IDX_W-1:0]     cur_idx;
    logic [DAT_WIDTH-1:0] cur_dat;
    logic [NB-1:0]        cur_sel;
    logic                 cur_we;
    logic                 cur_rng;
    logic                 enter_ack;
    logic [DAT_WIDTH-1:0] mem_rd;
    logic                 unused_adr;

    assign req     = t_cyc && t_stb;
    assign bus_idx = t_adr[OFS +: IDX_W];
    // In range only if every address bit above the word index is zero.
    assign bus_rng = ((t_adr >> (OFS + IDX_W)) == '0);
    // Byte-offset bits below the word index carry no information here.
    assign unused_adr = ^t_adr;

    // With zero wait states ACK is entered on the sampling edge itself, so the
    // memory must see the live bus; otherwise it sees the captured request.
    always_comb begin
        if (state_q == IDLE) begin
            cur_idx = bus_idx;
            cur_dat = t_dat_w;
            cur_sel = t_sel;
            cur_we  = t_we;
            cur_rng = bus_rng;
        end else begin
            cur_idx = idx_q;
            cur_dat = dat_q;
            cur_sel = sel_q;
            cur_we  = we_q;
            cur_rng = rng_q;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; WAIT aborts back to IDLE if the initiator drops cyc.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req) state_d = (WAIT_STATES == 0) ? ACK : WAIT;
            WAIT: begin
                if (!t_cyc)              state_d = IDLE;
                else if (wcnt_q == '0)   state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ack is a pure state decode; read data is shown only while acking.
    always_comb begin
        t_ack   = (state_q == ACK);
        t_dat_r = '0;
        if (state_q == ACK && !we_q && rng_q) t_dat_r = mem_rd;
    end

    // Write and read both happen on the edge that enters ACK; reset cancels it.
    assign enter_ack = (state_d == ACK) && !reset;

    // Wait-state countdown.
    always_ff @(posedge clock) begin
        if (reset)                                wcnt_q <= '0;
        else if (state_q == IDLE && req)          wcnt_q <= WAIT_INIT;
        else if (state_q == WAIT && wcnt_q != '0) wcnt_q <= wcnt_q - 1'b1;
    end

    // Capture the request when it is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
            rng_q <= 1'b0;
        end else if (state_q == IDLE && req) begin
            idx_q <= bus_idx;
            dat_q <= t_dat_w;
            sel_q <= t_sel;
            we_q  <= t_we;
            rng_q <= bus_rng;
        end
    end

    // Count completed transfers on the ACK -> IDLE edge.
    always_ff @(posedge clock) begin
        if (reset)               access_cnt <= '0;
        else if (state_q == ACK) access_cnt <= access_cnt + 16'd1;
    end

    wb_target_mem #(
        .DAT_WIDTH (DAT_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clock  (clock),
        .idx    (cur_idx),
        .wr_en  (enter_ack && cur_we && cur_rng),
        .wr_be  (cur_sel),
        .wr_dat (cur_dat),
        .rd_en  (enter_ack && !cur_we && cur_rng),
        .rd_dat (mem_rd)
    );

endmodule

// File: tb/tb_wb_mem_target.sv
// Bench for wb_mem_target: one instance with no wait states, one with three,
// checked against an array model of the memory and a transfer counter.
module tb_wb_mem_target;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][31:0] adr, dw, dr;
    logic [1:0][3:0]  sel;
    logic [1:0]       cyc, stb, we, ack;
    logic [1:0][15:0] cnt;

    wb_mem_target #(.WAIT_STATES(0)) dut0 (
        .clock(clk), .reset(rst), .t_adr(adr[0]), .t_dat_w(dw[0]), .t_dat_r(dr[0]),
        .t_cyc(cyc[0]), .t_stb(stb[0]), .t_sel(sel[0]), .t_we(we[0]), .t_ack(ack[0]),
        .access_cnt(cnt[0]));

    wb_mem_target #(.WAIT_STATES(3)) dut3 (
        .clock(clk), .reset(rst), .t_adr(adr[1]), .t_dat_w(dw[1]), .t_dat_r(dr[1]),
        .t_cyc(cyc[1]), .t_stb(stb[1]), .t_sel(sel[1]), .t_we(we[1]), .t_ack(ack[1]),
        .access_cnt(cnt[1]));

    int          n_chk = 0;
    int          n_fail = 0;
    int          ws [2] = '{0, 3};
    logic [31:0] mm [2][DEPTH];
    int          acc [2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < DEPTH;
    endfunction

    function automatic logic [31:0] model_rd(input int w, input logic [31:0] a);
        return in_rng(a) ? mm[w][a >> 2] : 32'h0;
    endfunction

    task automatic model_wr(input int w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic [31:0] v;
        if (!in_rng(a)) return;
        v = mm[w][a >> 2];
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        mm[w][a >> 2] = v;
    endtask

    // One bus transfer; returns read data and edges from stb sampling to ack.
    // Leaves the time #1 after the ACK -> IDLE edge.
    task automatic bus(input int w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic wr,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        adr[w] = a; dw[w] = d; sel[w] = s; we[w] = wr; cyc[w] = 1'b1; stb[w] = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack[w] && lat < 40);
        rd = dr[w];
        cyc[w] = 1'b0; stb[w] = 1'b0;
        @(posedge clk); #1;
    endtask

    // Transfer plus model update and checks of latency and read data.
    task automatic xfer(input int w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic wr, input string tag,
                        output logic [31:0] rd);
        int lat;
        bus(w, a, d, s, wr, rd, lat);
        chk({tag, "_lat"}, lat, ws[w] + 1);
        acc[w]++;
        if (wr) model_wr(w, a, d, s);
        else    chk({tag, "_rd"}, rd, model_rd(w, a));
    endtask

    initial begin
        logic [31:0] rd, a, prior;
        logic        seen;
        int          lat;

        adr = '0; dw = '0; sel = '0; cyc = '0; stb = '0; we = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            chk("rst_ack", ack[w], 0);
            chk("rst_dat", dr[w], 0);
            chk("rst_cnt", cnt[w], 0);
        end
        @(negedge clk); rst = 1'b0;

        // Write then read with no wait states
        xfer(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, "t1_wr", rd);
        bus(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, lat);
        acc[0]++;
        chk("t1_rd_lat", lat, 1);
        chk("t1_rd", rd, 32'hDEADBEEF);
        chk("t1_cnt", cnt[0], 2);

        // Fill both memories so every later read has a known value
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < DEPTH; i++)
                xfer(w, i * 4, $urandom, 4'hF, 1'b1, "fill", rd);

        // Byte lanes
        xfer(0, 32'h20, 32'h11223344, 4'hF, 1'b1, "t2_wr0", rd);
        xfer(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, "t2_wr1", rd);
        xfer(0, 32'h20, 32'h0, 4'h0, 1'b0, "t2", rd);
        chk("t2_lanes", rd, 32'h11BB33DD);
        xfer(0, 32'h24, 32'hFFFFFFFF, 4'h0, 1'b1, "t2_sel0", rd);
        xfer(0, 32'h24, 32'h0, 4'h0, 1'b0, "t2_sel0", rd);

        // Three wait states: latency, single-cycle ack, data cleared afterwards
        xfer(1, 32'h10, 32'h0, 4'hF, 1'b0, "t3", rd);
        chk("t3_ack_drop", ack[1], 0);
        chk("t3_dat_zero", dr[1], 0);
        chk("t3_cnt", cnt[1], acc[1]);

        // Aborted write during WAIT
        prior = mm[1][32'h30 >> 2];
        @(negedge clk);
        adr[1] = 32'h30; dw[1] = 32'h55555555; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; seen |= ack[1]; end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= ack[1]; end
        chk("t4_noack", seen, 0);
        chk("t4_cnt", cnt[1], acc[1]);
        xfer(1, 32'h30, 32'h0, 4'h0, 1'b0, "t4", rd);
        chk("t4_prior", rd, prior);

        // Out of range: write dropped but acked, read returns zero
        prior = mm[0][0];
        xfer(0, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, "t5_wr", rd);
        xfer(0, 32'h400, 32'h0, 4'hF, 1'b0, "t5_oor", rd);
        chk("t5_oor_zero", rd, 0);
        xfer(0, 32'h0, 32'h0, 4'hF, 1'b0, "t5_w0", rd);
        chk("t5_w0_kept", rd, prior);
        xfer(0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, "t5_hi", rd);
        chk("t5_cnt", cnt[0], acc[0]);

        // Reset during WAIT: write never commits, counters clear
        @(negedge clk);
        adr[1] = 32'h34; dw[1] = 32'hCAFEF00D; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk); #1;
        chk("t6_ack", ack[1], 0);
        chk("t6_dat", dr[1], 0);
        chk("t6_cnt0", cnt[0], 0);
        chk("t6_cnt3", cnt[1], 0);
        acc[0] = 0; acc[1] = 0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_ack_after", ack[1], 0);

        // Random traffic against the model
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 1279);
            if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
            xfer(0, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rnd0", rd);
        end
        chk("rnd0_cnt", cnt[0], 1000);

        xfer(1, 32'h34, 32'h0, 4'hF, 1'b0, "t6_34", rd);
        for (int i = 0; i < 150; i++) begin
            a = $urandom_range(0, 1279);
            xfer(1, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rnd3", rd);
        end
        chk("rnd3_cnt", cnt[1], acc[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
